// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the memory slave and its bench.
// Contents:
//   htrans_e     - transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_e      - transfer size encoding (BYTE..DWORD)
//   HRESP_*      - response encodings
//   slv_state_e  - response FSM states of the memory slave
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HALF  = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slv_state_e;

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-organised synchronous RAM for the AHB-Lite memory slave.
// Ports:
//   clk_i    - clock, all state on rising edge
//   rst_ni   - async active-low reset (clears the read register only, not the array)
//   we_i     - per-byte write enables, little-endian lanes
//   waddr_i  - write word index
//   wdata_i  - write data
//   re_i     - read enable; rdata_o updates on the edge it is sampled high
//   raddr_i  - read word index
//   rdata_o  - registered read data (read-before-write on a same-edge collision)
module ahb_slv_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DATA_W/8-1:0]        we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// Parametrised AHB-Lite memory slave: SRAM behind an address/data-phase pipeline with
// configurable wait states and byte-lane writes decoded from HSIZE/HADDR.
// Optional feature macro: AHB_SLV_ERR_RESP_EN
//   defined     - bad accesses get a two-cycle ERROR response, no wait states
//   not defined - bad accesses complete OKAY with normal wait states, writes dropped, reads 0
// Bad access: word index >= DEPTH, HSIZE wider than the bus, or address misaligned for HSIZE.
// Ports:
//   HCLK      - bus clock
//   HRSTN     - async active-low reset
//   HSEL      - slave select (address phase)
//   HADDR     - byte address (address phase)
//   HTRANS    - transfer type; NONSEQ/SEQ start a transfer
//   HWRITE    - 1 = write
//   HSIZE     - transfer size
//   HWDATA    - write data (data phase)
//   HREADY    - bus ready; address phase accepted only when high
//   HREADYOUT - slave ready
//   HRESP     - 0 = OKAY, 1 = ERROR
//   HRDATA    - read data, held outside read data phases
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRSTN,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic [2:0]        MAX_SIZE = (DATA_W == 64) ? DWORD : WORD;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]        WS_INIT  = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  // Address-phase decode
  logic [ADDR_W-OFF_W-1:0] word_full;
  logic [OFF_W-1:0]        lane_off;
  logic [OFF_W-1:0]        align_mask;
  logic [IDX_W-1:0]        idx;
  logic [NB-1:0]           be;
  logic                    range_err;
  logic                    size_err;
  logic                    align_err;
  logic                    addr_err;
  logic                    err_resp;
  logic                    accept;

  // Data-phase pipeline and FSM
  slv_state_e       state_q;
  logic [2:0]       wait_cnt_q;
  logic             hreadyout_q;
  logic             hresp_q;
  logic             dp_write_q;
  logic             dp_err_q;
  logic [IDX_W-1:0] dp_idx_q;
  logic [NB-1:0]    dp_be_q;
  logic             commit;

  // Read path
  logic              ram_re;
  logic [NB-1:0]     ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              rd_zero_q;
  logic [NB-1:0]     rd_fwd_be_q;
  logic [DATA_W-1:0] rd_fwd_data_q;

  assign word_full = HADDR[ADDR_W-1:OFF_W];
  assign lane_off  = HADDR[OFF_W-1:0];
  assign idx       = word_full[IDX_W-1:0];

  assign range_err = {{(OFF_W + 1){1'b0}}, word_full} >= DEPTH_L;
  assign size_err  = HSIZE > MAX_SIZE;

  always_comb begin
    align_mask = '0;
    for (int unsigned i = 0; i < OFF_W; i++) begin
      align_mask[i] = 32'(i) < 32'(HSIZE);
    end
  end

  assign align_err = |(lane_off & align_mask);
  assign addr_err  = range_err | size_err | align_err;

  // Lanes [lane_off, lane_off + 2**HSIZE) are written
  always_comb begin
    int unsigned lo;
    int unsigned hi;
    lo = 32'(lane_off);
    hi = lo + (32'd1 << HSIZE);
    be = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be[i] = (i >= lo) && (i < hi);
    end
  end

`ifdef AHB_SLV_ERR_RESP_EN
  assign err_resp = addr_err;
`else
  assign err_resp = 1'b0;
`endif

  // HREADYOUT gate keeps a stray HREADY from starting a transfer while this slave stalls
  assign accept = HSEL && HREADY && hreadyout_q && (HTRANS == NONSEQ || HTRANS == SEQ);

  // Write commits on the last data-phase edge, which is the only S_DATA edge
  assign commit = (state_q == S_DATA) && dp_write_q && !dp_err_q;

  always_ff @(posedge HCLK or negedge HRSTN) begin
    if (!HRSTN) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      dp_write_q  <= 1'b0;
      dp_err_q    <= 1'b0;
      dp_idx_q    <= '0;
      dp_be_q     <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        S_IDLE, S_DATA, S_ERR2: begin
          // Slave is ready here, so the next address phase may overlap
          if (accept) begin
            dp_write_q <= HWRITE;
            dp_err_q   <= addr_err;
            dp_idx_q   <= idx;
            dp_be_q    <= be;
            if (err_resp) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WAIT_STATES != 0) begin
              state_q     <= S_WAIT;
              wait_cnt_q  <= WS_INIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state_q     <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            dp_write_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign ram_we = commit ? dp_be_q : '0;
  assign ram_re = accept && !HWRITE && !addr_err;

  ahb_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (HCLK),
    .rst_ni  (HRSTN),
    .we_i    (ram_we),
    .waddr_i (dp_idx_q),
    .wdata_i (HWDATA),
    .re_i    (ram_re),
    .raddr_i (idx),
    .rdata_o (ram_rdata)
  );

  // The RAM reads before the commit on a shared edge, so capture the bytes being written
  // to the same word and overlay them on the read result.
  always_ff @(posedge HCLK or negedge HRSTN) begin
    if (!HRSTN) begin
      rd_zero_q     <= 1'b1;
      rd_fwd_be_q   <= '0;
      rd_fwd_data_q <= '0;
    end else if (accept && !HWRITE) begin
      rd_zero_q     <= addr_err;
      rd_fwd_be_q   <= (commit && (dp_idx_q == idx)) ? dp_be_q : '0;
      rd_fwd_data_q <= HWDATA;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (!rd_zero_q) begin
      for (int unsigned b = 0; b < NB; b++) begin
        HRDATA[8*b +: 8] = rd_fwd_be_q[b] ? rd_fwd_data_q[8*b +: 8] : ram_rdata[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench for ahb_lite_mem_slave: a zero-wait instance driven through a
// scoreboard with a reference memory, and a three-wait-state instance for stall timing.
module tb_ahb_lite_mem_slave;
  import ahb_pkg::*;

`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hrstn;
  logic        hsel0, hsel3, hwrite, hready_blk;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready0, hreadyout0, hresp0;
  logic [31:0] hrdata0;
  logic        hready3, hreadyout3, hresp3;
  logic [31:0] hrdata3;

  assign hready0 = hreadyout0 & ~hready_blk;
  assign hready3 = hreadyout3;

  always #5 hclk = ~hclk;

  ahb_lite_mem_slave #(
    .ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)
  ) u_dut0 (
    .HCLK(hclk), .HRSTN(hrstn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0),
    .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0)
  );

  ahb_lite_mem_slave #(
    .ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(3)
  ) u_dut3 (
    .HCLK(hclk), .HRSTN(hrstn), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready3),
    .HREADYOUT(hreadyout3), .HRESP(hresp3), .HRDATA(hrdata3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference memory and scoreboard for u_dut0
  typedef struct {
    logic        rd;
    logic        err;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [1024];

  function automatic logic tb_err(input logic [15:0] a, input logic [2:0] s);
    int unsigned sz;
    int unsigned aa;
    sz = 32'(s);
    aa = 32'(a);
    return ((aa >> 2) >= 1024) || (sz > 2) || ((aa % (32'd1 << sz)) != 0);
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [2:0] s, input logic [31:0] d);
    int unsigned lo;
    int unsigned n;
    lo = 32'(a[1:0]);
    n  = 32'd1 << s;
    for (int unsigned b = 0; b < 4; b++) begin
      if (b >= lo && b < lo + n) mem_m[a[11:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  always @(negedge hclk) begin
    exp_t e;
    if (!hrstn) begin
      sb.delete();
    end else begin
      if (!hreadyout0) stall_cnt++;
      if (sb.size() != 0 && !hreadyout0)
        check_eq("hresp_stall", 32'(hresp0), (ERR_EN && sb[0].err) ? 32'd1 : 32'd0);
      if (sb.size() != 0 && hreadyout0) begin
        e = sb.pop_front();
        check_eq("hresp", 32'(hresp0), (ERR_EN && e.err) ? 32'd1 : 32'd0);
        if (e.rd) check_eq("hrdata", hrdata0, e.data);
        else if (!e.err) model_write(e.addr, e.size, hwdata);
      end
      if (hsel0 && hready0 && htrans[1]) begin
        e.rd   = !hwrite;
        e.err  = tb_err(haddr, hsize);
        e.addr = haddr;
        e.size = hsize;
        e.data = e.err ? 32'd0 : mem_m[haddr[11:2]];
        sb.push_back(e);
      end
    end
  end

  // Drive one address phase to u_dut0; returns just after it is accepted with the
  // write data (if any) placed on HWDATA for the data phase.
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [2:0] sz,
                      input logic [31:0] wd);
    int   n;
    logic ok;
    hsel0 = 1'b1; hsel3 = 1'b0; htrans = NONSEQ; hwrite = wr; haddr = a; hsize = sz;
    n = 0;
    do begin
      @(negedge hclk); ok = hready0;
      @(posedge hclk); #1; n++;
    end while (!ok && n < 50);
    check_eq("accept", 32'(ok), 32'd1);
    if (wr) hwdata = wd;
  endtask

  // Idle the bus and wait for the outstanding data phase to complete.
  task automatic bus_idle();
    int   n;
    logic ok;
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = IDLE;
    n = 0;
    do begin
      @(negedge hclk); ok = hready0;
      @(posedge hclk); #1; n++;
    end while (!ok && n < 50);
    check_eq("complete", 32'(ok), 32'd1);
  endtask

  task automatic idle_cycle(input logic blk, input logic sel, input logic [1:0] tr);
    hready_blk = blk; hsel0 = sel; htrans = tr; hwrite = 1'b1; haddr = 16'h0040;
    hsize = WORD; hwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    check_eq("t6_hreadyout", 32'(hreadyout0), 32'd1);
    check_eq("t6_hresp", 32'(hresp0), 32'd0);
    @(posedge hclk); #1;
  endtask

  // Single transfer on u_dut3, counting HREADYOUT-low data-phase cycles.
  task automatic ws_xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                         output int lows, output logic [31:0] rd, output logic rsp);
    int   n;
    logic ok;
    hsel0 = 1'b0; hsel3 = 1'b1; htrans = NONSEQ; hwrite = wr; haddr = a; hsize = WORD;
    n = 0;
    do begin
      @(negedge hclk); ok = hready3;
      @(posedge hclk); #1; n++;
    end while (!ok && n < 50);
    check_eq("t4_accept", 32'(ok), 32'd1);
    if (wr) hwdata = wd;
    hsel3 = 1'b0; htrans = IDLE;
    lows = 0; n = 0; rd = '0; rsp = 1'b0;
    do begin
      @(negedge hclk); ok = hreadyout3;
      if (!ok) lows++;
      else begin rd = hrdata3; rsp = hresp3; end
      @(posedge hclk); #1; n++;
    end while (!ok && n < 50);
    check_eq("t4_complete", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0, lows;
    logic [31:0] rd;
    logic        rsp;

    hrstn = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0; hwrite = 1'b0; hready_blk = 1'b0;
    haddr = '0; htrans = IDLE; hsize = WORD; hwdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_eq("rst_hreadyout0", 32'(hreadyout0), 32'd1);
    check_eq("rst_hresp0", 32'(hresp0), 32'd0);
    check_eq("rst_hrdata0", hrdata0, 32'd0);
    check_eq("rst_hreadyout3", 32'(hreadyout3), 32'd1);
    check_eq("rst_hrdata3", hrdata3, 32'd0);
    @(posedge hclk); #1 hrstn = 1'b1;

    // Reset in the middle of a write data phase
    xfer(1'b1, 16'h0010, WORD, 32'hCAFE_F00D);
    xfer(1'b0, 16'h0010, WORD, 32'h0);
    bus_idle();
    xfer(1'b1, 16'h0010, WORD, 32'hDEAD_BEEF);
    hrstn = 1'b0; hsel0 = 1'b0; htrans = IDLE;
    @(negedge hclk);
    check_eq("t1_hreadyout", 32'(hreadyout0), 32'd1);
    check_eq("t1_hresp", 32'(hresp0), 32'd0);
    check_eq("t1_hrdata", hrdata0, 32'd0);
    @(posedge hclk); #1 hrstn = 1'b1;
    xfer(1'b0, 16'h0010, WORD, 32'h0);
    bus_idle();

    // Back-to-back write then read of the same word: forwarded, no stall
    xfer(1'b1, 16'h0020, WORD, 32'h0BAD_F00D);
    bus_idle();
    s0 = stall_cnt;
    xfer(1'b1, 16'h0020, WORD, 32'h1234_5678);
    xfer(1'b0, 16'h0020, WORD, 32'h0);
    bus_idle();
    check_eq("t2_stalls", 32'(stall_cnt - s0), 32'd0);

    // Byte and halfword lanes
    xfer(1'b1, 16'h0040, WORD, 32'hAABB_CCDD);
    xfer(1'b1, 16'h0042, BYTE, 32'hEE11_EEEE);
    xfer(1'b0, 16'h0040, WORD, 32'h0);
    bus_idle();
    xfer(1'b1, 16'h0044, WORD, 32'h0102_0304);
    xfer(1'b1, 16'h0046, HALF, 32'h5566_7788);
    bus_idle();
    xfer(1'b0, 16'h0044, WORD, 32'h0);
    bus_idle();

    // Wait states on the three-wait instance
    ws_xfer(1'b1, 16'h0008, 32'h5A5A_A5A5, lows, rd, rsp);
    check_eq("t4_write_lows", 32'(lows), 32'd3);
    ws_xfer(1'b0, 16'h0008, 32'h0, lows, rd, rsp);
    check_eq("t4_read_lows", 32'(lows), 32'd3);
    check_eq("t4_read_data", rd, 32'h5A5A_A5A5);
    check_eq("t4_read_resp", 32'(rsp), 32'd0);

    // Error cases: out of range, misaligned, oversize
    xfer(1'b0, 16'h0040, WORD, 32'h0);
    bus_idle();
    s0 = stall_cnt;
    xfer(1'b0, 16'h1000, WORD, 32'h0);
    bus_idle();
    check_eq("t5_err_stalls", 32'(stall_cnt - s0), ERR_EN ? 32'd1 : 32'd0);
    xfer(1'b1, 16'h0042, WORD, 32'hFFFF_FFFF);
    bus_idle();
    xfer(1'b0, 16'h0040, DWORD, 32'h0);
    bus_idle();
    xfer(1'b0, 16'h0040, WORD, 32'h0);
    bus_idle();

    // IDLE/BUSY, deselected, and HREADY low: no transfer, zero-wait OKAY
    s0 = stall_cnt;
    idle_cycle(1'b1, 1'b1, IDLE);
    idle_cycle(1'b1, 1'b1, BUSY);
    idle_cycle(1'b1, 1'b0, NONSEQ);
    idle_cycle(1'b1, 1'b1, NONSEQ);
    idle_cycle(1'b0, 1'b1, IDLE);
    idle_cycle(1'b0, 1'b1, BUSY);
    idle_cycle(1'b0, 1'b0, NONSEQ);
    hready_blk = 1'b0;
    bus_idle();
    check_eq("t6_stalls", 32'(stall_cnt - s0), 32'd0);
    xfer(1'b0, 16'h0040, WORD, 32'h0);
    bus_idle();
    repeat (2) @(posedge hclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
